lsu_master: RTL and testbench

LSU_MASTER -- requirements
Module: lsu_master

---
 rtl/lsu_master.sv | 162 ++++++++++++++++
 tb/tb_lsu_master.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_master.sv
// Load/store unit memory master: accepts one M-stage access, issues it to memory, returns one response.
// Define LSU_LB_SIGNEXT_EN to sign-extend byte loads; zero-extension is the default.
module lsu_master #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic        req_byte,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int CntWidth = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } stateT;

    stateT               state;
    stateT               nextState;
    logic                weReg;
    logic                byteReg;
    logic [31:0]         addrReg;
    logic [31:0]         wdataReg;
    logic [31:0]         rdataReg;
    logic                errReg;
    logic [CntWidth-1:0] cycleCnt;
    logic                misaligned;
    logic                timeoutHit;
    logic [7:0]          laneByte;
    logic [31:0]         byteExt;

    // The PC travels with the request for tracing only; the datapath never needs it.
    logic unusedPc;
    assign unusedPc = ^req_pc;

    assign misaligned = !req_byte && (req_addr[1:0] != 2'b00);
    assign timeoutHit = (cycleCnt == CntWidth'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            weReg    <= 1'b0;
            byteReg  <= 1'b0;
            addrReg  <= '0;
            wdataReg <= '0;
            rdataReg <= '0;
            errReg   <= 1'b0;
            cycleCnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        weReg    <= req_we;
                        byteReg  <= req_byte;
                        addrReg  <= req_addr;
                        wdataReg <= req_wdata;
                        rdataReg <= '0;
                        errReg   <= misaligned;
                        cycleCnt <= '0;
                    end
                end
                ISSUE: begin
                    // An ack landing on the timeout edge still counts as a clean completion.
                    if (mem_ack) begin
                        rdataReg <= mem_rdata;
                        errReg   <= 1'b0;
                    end else if (timeoutHit) begin
                        errReg <= 1'b1;
                    end else begin
                        cycleCnt <= cycleCnt + CntWidth'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        laneByte = 8'h00;
        case (addrReg[1:0])
            2'd0: laneByte = rdataReg[7:0];
            2'd1: laneByte = rdataReg[15:8];
            2'd2: laneByte = rdataReg[23:16];
            2'd3: laneByte = rdataReg[31:24];
            default: laneByte = 8'h00;
        endcase
    end

`ifdef LSU_LB_SIGNEXT_EN
    assign byteExt = {{24{laneByte[7]}}, laneByte};
`else
    assign byteExt = {24'h000000, laneByte};
`endif

    always_comb begin
        nextState  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        resp_err   = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_be     = 4'b0000;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    nextState = misaligned ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                mem_en    = 1'b1;
                mem_we    = weReg;
                mem_addr  = {addrReg[31:2], 2'b00};
                mem_be    = byteReg ? (4'b0001 << addrReg[1:0]) : 4'b1111;
                mem_wdata = byteReg ? {4{wdataReg[7:0]}} : wdataReg;
                if (mem_ack || timeoutHit) begin
                    nextState = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = errReg;
                if (!errReg && !weReg) begin
                    resp_rdata = byteReg ? byteExt : rdataReg;
                end
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lsu_master.sv
// Directed self-checking bench for lsu_master, built with TIMEOUT=4 so the timeout path is short.
module tb_lsu_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic        req_byte;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checkCount = 0;
    int passCount  = 0;

    lsu_master #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_byte   (req_byte),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_pc     (req_pc),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for a single edge; returns one step after the accepting edge.
    task automatic applyStimulus(input logic we, input logic isByte, input logic [31:0] addr, input logic [31:0] wdata);
        req_valid = 1'b1;
        req_we    = we;
        req_byte  = isByte;
        req_addr  = addr;
        req_wdata = wdata;
        req_pc    = 32'h0000_1000 + addr;
        checkOutput("ready_before_accept", {31'b0, req_ready}, 32'd1);
        nextCycle();
        req_valid = 1'b0;
    endtask

    logic [31:0] expLb3;
    logic [31:0] expLb2;

    initial begin
`ifdef LSU_LB_SIGNEXT_EN
        expLb3 = 32'hFFFF_FF80;
        expLb2 = 32'hFFFF_FFFF;
`else
        expLb3 = 32'h0000_0080;
        expLb2 = 32'h0000_00FF;
`endif
        reset     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_byte  = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_pc    = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        nextCycle();
        nextCycle();
        checkOutput("rst_ready", {31'b0, req_ready}, 32'd1);
        checkOutput("rst_mem_en", {31'b0, mem_en}, 32'd0);
        checkOutput("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        checkOutput("rst_resp_rdata", resp_rdata, 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        reset = 1'b1;

        // Word store at 0x10, ack two cycles after mem_en rises.
        applyStimulus(1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF);
        for (int i = 0; i < 2; i++) begin
            checkOutput("sw_mem_en", {31'b0, mem_en}, 32'd1);
            checkOutput("sw_mem_be", {28'b0, mem_be}, 32'hF);
            checkOutput("sw_mem_addr", mem_addr, 32'h10);
            checkOutput("sw_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
            checkOutput("sw_mem_we", {31'b0, mem_we}, 32'd1);
            checkOutput("sw_ready_busy", {31'b0, req_ready}, 32'd0);
            if (i == 1) mem_ack = 1'b1;
            nextCycle();
        end
        mem_ack = 1'b0;
        checkOutput("sw_resp_valid", {31'b0, resp_valid}, 32'd1);
        checkOutput("sw_resp_err", {31'b0, resp_err}, 32'd0);
        checkOutput("sw_resp_rdata", resp_rdata, 32'd0);
        checkOutput("sw_mem_en_off", {31'b0, mem_en}, 32'd0);
        nextCycle();
        checkOutput("sw_resp_pulse", {31'b0, resp_valid}, 32'd0);
        checkOutput("sw_ready_back", {31'b0, req_ready}, 32'd1);

        // Byte load at 0x13 picks the top lane.
        applyStimulus(1'b0, 1'b1, 32'h13, 32'h0);
        checkOutput("lb3_mem_be", {28'b0, mem_be}, 32'h8);
        checkOutput("lb3_mem_addr", mem_addr, 32'h10);
        checkOutput("lb3_mem_we", {31'b0, mem_we}, 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h80FF_0011;
        nextCycle();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        checkOutput("lb3_resp_valid", {31'b0, resp_valid}, 32'd1);
        checkOutput("lb3_resp_rdata", resp_rdata, expLb3);
        checkOutput("lb3_resp_err", {31'b0, resp_err}, 32'd0);
        nextCycle();

        // Byte load at 0x12 picks lane 2.
        applyStimulus(1'b0, 1'b1, 32'h12, 32'h0);
        checkOutput("lb2_mem_be", {28'b0, mem_be}, 32'h4);
        mem_ack   = 1'b1;
        mem_rdata = 32'h80FF_0011;
        nextCycle();
        mem_ack = 1'b0;
        checkOutput("lb2_resp_rdata", resp_rdata, expLb2);
        nextCycle();

        // Byte store at 0x21 replicates the byte on every lane.
        applyStimulus(1'b1, 1'b1, 32'h21, 32'h0000_00AB);
        checkOutput("sb_mem_be", {28'b0, mem_be}, 32'h2);
        checkOutput("sb_mem_wdata", mem_wdata, 32'hABAB_ABAB);
        checkOutput("sb_mem_addr", mem_addr, 32'h20);
        mem_ack = 1'b1;
        nextCycle();
        mem_ack = 1'b0;
        checkOutput("sb_resp_valid", {31'b0, resp_valid}, 32'd1);
        checkOutput("sb_resp_rdata", resp_rdata, 32'd0);
        nextCycle();

        // Word load at 0x08 returns the whole word.
        applyStimulus(1'b0, 1'b0, 32'h08, 32'h0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
        nextCycle();
        mem_ack = 1'b0;
        checkOutput("lw_resp_rdata", resp_rdata, 32'h1234_5678);
        checkOutput("lw_resp_err", {31'b0, resp_err}, 32'd0);
        nextCycle();

        // Misaligned word load at 0x06 skips memory entirely.
        applyStimulus(1'b0, 1'b0, 32'h06, 32'h0);
        checkOutput("mis_mem_en", {31'b0, mem_en}, 32'd0);
        checkOutput("mis_resp_valid", {31'b0, resp_valid}, 32'd1);
        checkOutput("mis_resp_err", {31'b0, resp_err}, 32'd1);
        checkOutput("mis_resp_rdata", resp_rdata, 32'd0);
        nextCycle();
        checkOutput("mis_resp_pulse", {31'b0, resp_valid}, 32'd0);
        checkOutput("mis_ready_back", {31'b0, req_ready}, 32'd1);

        // Ack held low: four cycles of mem_en, then an error response.
        applyStimulus(1'b0, 1'b0, 32'h40, 32'h0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("to_mem_en", {31'b0, mem_en}, 32'd1);
            checkOutput("to_no_resp", {31'b0, resp_valid}, 32'd0);
            nextCycle();
        end
        checkOutput("to_mem_en_off", {31'b0, mem_en}, 32'd0);
        checkOutput("to_resp_valid", {31'b0, resp_valid}, 32'd1);
        checkOutput("to_resp_err", {31'b0, resp_err}, 32'd1);
        checkOutput("to_resp_rdata", resp_rdata, 32'd0);
        nextCycle();
        checkOutput("to_ready_back", {31'b0, req_ready}, 32'd1);

        // Ack arriving on the timeout edge is a normal completion.
        applyStimulus(1'b0, 1'b0, 32'h44, 32'h0);
        nextCycle();
        nextCycle();
        nextCycle();
        checkOutput("toack_mem_en", {31'b0, mem_en}, 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        nextCycle();
        mem_ack = 1'b0;
        checkOutput("toack_resp_valid", {31'b0, resp_valid}, 32'd1);
        checkOutput("toack_resp_err", {31'b0, resp_err}, 32'd0);
        checkOutput("toack_resp_rdata", resp_rdata, 32'hCAFE_F00D);
        nextCycle();

        // Stray ack in IDLE produces nothing.
        mem_ack = 1'b1;
        nextCycle();
        mem_ack = 1'b0;
        checkOutput("idle_ack_resp", {31'b0, resp_valid}, 32'd0);
        checkOutput("idle_ack_mem_en", {31'b0, mem_en}, 32'd0);

        // Reset in the middle of ISSUE drops the transaction.
        applyStimulus(1'b0, 1'b0, 32'h50, 32'h0);
        checkOutput("rmid_mem_en", {31'b0, mem_en}, 32'd1);
        reset = 1'b0;
        nextCycle();
        reset = 1'b1;
        checkOutput("rmid_mem_en_off", {31'b0, mem_en}, 32'd0);
        checkOutput("rmid_ready", {31'b0, req_ready}, 32'd1);
        mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            checkOutput("rmid_no_resp", {31'b0, resp_valid}, 32'd0);
        end
        mem_ack = 1'b0;

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
